// File: rtl/bram_pkg.sv
// Shared sizes and word/address types for the 2048x8 dual-port block RAM.
package bram_pkg;

  localparam int BRAM_ADDR_W = 11;
  localparam int BRAM_DATA_W = 8;
  localparam int BRAM_DEPTH  = 2 ** BRAM_ADDR_W;

  typedef logic [BRAM_ADDR_W-1:0] bram_addr_t;
  typedef logic [BRAM_DATA_W-1:0] bram_word_t;

endpackage

// File: rtl/bram_rd_port.sv
// Registered read-data output for one RAM port: sync active-low clear, holds while disabled.
module bram_rd_port
  import bram_pkg::*;
#(
  parameter int DATA_W = BRAM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              ce_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (!rstn_i) begin
      q_d = '0;
    end else if (ce_i) begin
      q_d = rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/bram_2048x8.sv
// True dual-port 2048x8 RAM with per-bit write masks, read-first outputs and
// port 1 taking priority on same-address write collisions.
module bram_2048x8
  import bram_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CE0,
  input  logic [ADDR_W-1:0] A0,
  input  logic [DATA_W-1:0] D0,
  input  logic              WE0,
  input  logic [DATA_W-1:0] WEM0,
  output logic [DATA_W-1:0] Q0,
  input  logic              CE1,
  input  logic [ADDR_W-1:0] A1,
  input  logic [DATA_W-1:0] D1,
  input  logic              WE1,
  input  logic [DATA_W-1:0] WEM1,
  output logic [DATA_W-1:0] Q1
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;

  // Port 1 is applied after port 0 so its bits win where both masks overlap.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      if (CE0 && WE0) begin
        for (int i = 0; i < DATA_W; i++) begin
          if (WEM0[i]) mem[A0][i] <= D0[i];
        end
      end
      if (CE1 && WE1) begin
        for (int i = 0; i < DATA_W; i++) begin
          if (WEM1[i]) mem[A1][i] <= D1[i];
        end
      end
    end
  end

  // Pre-update contents feed both output registers, giving read-first behaviour.
  assign rd0 = mem[A0];
  assign rd1 = mem[A1];

  bram_rd_port #(.DATA_W(DATA_W)) u_rd0 (
    .clk_i  (CLK),
    .rstn_i (RSTN),
    .ce_i   (CE0),
    .rdata_i(rd0),
    .q_o    (Q0)
  );

  bram_rd_port #(.DATA_W(DATA_W)) u_rd1 (
    .clk_i  (CLK),
    .rstn_i (RSTN),
    .ce_i   (CE1),
    .rdata_i(rd1),
    .q_o    (Q1)
  );

endmodule

// File: tb/tb_bram_2048x8.sv
// Directed bench for bram_2048x8: word-level reference model checked every cycle plus literal checks.
module tb_bram_2048x8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ce0, we0, ce1, we1;
  logic [10:0] a0, a1;
  logic [7:0]  d0, wem0, d1, wem1;
  logic [7:0]  q0, q1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bram_2048x8 dut (
    .CLK(clk), .RSTN(rstn),
    .CE0(ce0), .A0(a0), .D0(d0), .WE0(we0), .WEM0(wem0), .Q0(q0),
    .CE1(ce1), .A1(a1), .D1(d1), .WE1(we1), .WEM1(wem1), .Q1(q1)
  );

  always #5 clk = ~clk;

  // Reference model: memory as an array of words, outputs as expected registers.
  logic [7:0] model [0:2047];
  logic [7:0] exp0 = 8'h00;
  logic [7:0] exp1 = 8'h00;
  logic [7:0] old0, old1, nxt0, base1, nxt1;
  logic       wr0, wr1;

  initial begin
    for (int k = 0; k < 2048; k++) model[k] = 8'h00;
  end

  function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] d, input logic [7:0] m);
    return (old & ~m) | (d & m);
  endfunction

  always_comb begin
    old0  = model[a0];
    old1  = model[a1];
    wr0   = rstn && ce0 && we0;
    wr1   = rstn && ce1 && we1;
    nxt0  = wr0 ? merge(old0, d0, wem0) : old0;
    base1 = (wr0 && a0 == a1) ? nxt0 : old1;
    nxt1  = wr1 ? merge(base1, d1, wem1) : base1;
  end

  always @(posedge clk) begin
    if (!rstn) begin
      exp0 <= 8'h00;
      exp1 <= 8'h00;
    end else begin
      if (ce0) exp0 <= old0;
      if (ce1) exp1 <= old1;
    end
    if (wr0) model[a0] <= nxt0;
    if (wr1) model[a1] <= nxt1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_q0", q0, exp0);
      check("model_q1", q1, exp1);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce0 = 0; we0 = 0; wem0 = 8'h00; d0 = 8'h00; a0 = '0;
    ce1 = 0; we1 = 0; wem1 = 8'h00; d1 = 8'h00; a1 = '0;
  endtask

  task automatic wr_p0(input logic [10:0] a, input logic [7:0] d, input logic [7:0] m);
    ce0 = 1; we0 = 1; a0 = a; d0 = d; wem0 = m;
  endtask

  task automatic wr_p1(input logic [10:0] a, input logic [7:0] d, input logic [7:0] m);
    ce1 = 1; we1 = 1; a1 = a; d1 = d; wem1 = m;
  endtask

  task automatic rd_p0(input logic [10:0] a);
    ce0 = 1; we0 = 0; a0 = a;
  endtask

  task automatic rd_p1(input logic [10:0] a);
    ce1 = 1; we1 = 0; a1 = a;
  endtask

  logic [10:0] sx;

  initial begin
    idle();
    rstn = 0;
    cycle();
    cycle();
    chk_en = 1'b1;
    check("reset_q0", q0, 8'h00);
    check("reset_q1", q1, 8'h00);
    rstn = 1;

    // Bring the array to the all-zero state the model starts from.
    for (int k = 0; k < 2048; k++) begin
      idle(); wr_p0(11'(k), 8'h00, 8'hFF); cycle();
    end
    idle(); cycle();

    // Masked write, then read back through port 1.
    wr_p0(11'h7FF, 8'hA5, 8'hFF); cycle();
    wr_p0(11'h7FF, 8'h00, 8'h0F); cycle();
    idle(); rd_p1(11'h7FF);
    check("mask_q1_before", q1, 8'h00);
    cycle();
    check("mask_q1", q1, 8'hA0);

    // Reset clears outputs, blocks writes, keeps contents.
    idle(); rd_p0(11'h7FF); cycle();
    check("pre_rst_q0", q0, 8'hA0);
    idle(); rstn = 0; wr_p0(11'h7FF, 8'hFF, 8'hFF); cycle();
    check("rst_q0", q0, 8'h00);
    check("rst_q1", q1, 8'h00);
    rstn = 1; idle(); rd_p0(11'h7FF); rd_p1(11'h7FF); cycle();
    check("post_rst_q0", q0, 8'hA0);
    check("post_rst_q1", q1, 8'hA0);

    // Read-first on the writing port, then hold while disabled.
    idle(); wr_p0(11'h010, 8'h11, 8'hFF); cycle();
    wr_p0(11'h010, 8'h3C, 8'hFF); cycle();
    check("rdfirst_q0", q0, 8'h11);
    idle(); rd_p0(11'h010); cycle();
    check("rd10_q0", q0, 8'h3C);
    idle();
    for (int k = 0; k < 3; k++) begin
      a0 = 11'(k * 7); we0 = 1; wem0 = 8'hFF; d0 = 8'hEE;
      cycle();
      check("hold_q0", q0, 8'h3C);
    end

    // Write/write collision: port 1 wins on overlapping mask bits.
    idle(); wr_p0(11'h005, 8'hFF, 8'hFF); wr_p1(11'h005, 8'h00, 8'hF0); cycle();
    idle(); rd_p0(11'h005); cycle();
    check("ww_q0", q0, 8'h0F);

    // Write/read collision: reader sees old word this cycle, new next cycle.
    idle(); wr_p0(11'h009, 8'h22, 8'hFF); cycle();
    wr_p0(11'h009, 8'h77, 8'hFF); rd_p1(11'h009); cycle();
    check("wr_q1_old", q1, 8'h22);
    idle(); rd_p1(11'h009); rd_p0(11'h009); cycle();
    check("wr_q1_new", q1, 8'h77);
    check("rr_q0", q0, 8'h77);

    // Legal no-op write with an empty mask.
    idle(); wr_p1(11'h009, 8'h00, 8'h00); cycle();
    idle(); rd_p0(11'h009); cycle();
    check("nomask_q0", q0, 8'h77);

    // Full sweep: write addr^5A via port 1, read back via port 0.
    for (int k = 0; k < 2048; k++) begin
      sx = 11'(k) ^ 11'h05A;
      idle(); wr_p1(11'(k), sx[7:0], 8'hFF); cycle();
    end
    for (int k = 0; k < 2048; k++) begin
      sx = 11'(k) ^ 11'h05A;
      idle(); rd_p0(11'(k)); cycle();
      check("sweep_q0", q0, sx[7:0]);
    end
    idle(); rd_p1(11'h000); cycle();
    check("sweep_addr0_q1", q1, 8'h5A);
    idle(); rd_p1(11'h7FF); cycle();
    check("sweep_addr7ff_q1", q1, 8'hA5);

    idle(); cycle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
